// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
// Handshake: start accepted in IDLE, busy while working, done pulses with the result.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam logic [XLEN-1:0] MinSigned = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic                 neg_q, special_q;
    logic [XLEN-1:0]      spec_val_q, b_q, result_q;
    logic [2*XLEN-1:0]    acc_q;
    logic [XLEN:0]        rem_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 done_q, illegal_q;

    // Decode of the request presented on the inputs
    logic            valid_op, req, accept, reject;
    logic            signed_a, signed_b, sa, sb, div_zero, ovf, special_in;
    logic [XLEN-1:0] abs_a, abs_b, spec_val_in;

    always_comb begin
        valid_op    = (opcode == 7'b0110011) && (func7 == 7'h01);
        // The done cycle is treated like FIN: a start there is neither accepted nor flagged
        req         = (state_q == StIdle) && start && !done_q;
        accept      = req && valid_op;
        reject      = req && !valid_op;
        signed_a    = (func3 == 3'd1) || (func3 == 3'd2) || (func3 == 3'd4) || (func3 == 3'd6);
        signed_b    = (func3 == 3'd1) || (func3 == 3'd4) || (func3 == 3'd6);
        sa          = signed_a && rs1[XLEN-1];
        sb          = signed_b && rs2[XLEN-1];
        abs_a       = sa ? -rs1 : rs1;
        abs_b       = sb ? -rs2 : rs2;
        div_zero    = func3[2] && (rs2 == '0);
        ovf         = ((func3 == 3'd4) || (func3 == 3'd6)) && (rs1 == MinSigned) && (rs2 == '1);
        special_in  = div_zero || ovf;
        if (div_zero) spec_val_in = func3[1] ? rs1 : '1;
        else          spec_val_in = func3[1] ? '0 : MinSigned;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = special_in ? StFin : StCalc;
            StCalc: if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q != StIdle);
        done    = done_q;
        result  = result_q;
        illegal = illegal_q;
    end

    // Datapath step values
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_val;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quot_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        final_val = '0;
        if (special_q) begin
            final_val = spec_val_q;
        end else begin
            unique case (op_q)
                3'd0:                final_val = acc_q[XLEN-1:0];
                3'd1, 3'd2, 3'd3:    final_val = prod_fix[2*XLEN-1:XLEN];
                3'd4, 3'd5:          final_val = quot_fix;
                default:             final_val = rem_fix;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            done_q    <= (state_q == StFin);
            illegal_q <= reject;
            if (accept) begin
                op_q       <= func3;
                // REM follows the dividend sign; everything else the product of signs
                neg_q      <= (func3 == 3'd6) ? sa : (sa ^ sb);
                special_q  <= special_in;
                spec_val_q <= spec_val_in;
                b_q        <= abs_b;
                acc_q      <= {{XLEN{1'b0}}, abs_a};
                rem_q      <= '0;
                cnt_q      <= '0;
            end else if (state_q == StCalc) begin
                cnt_q <= cnt_q + 1'b1;
                if (op_q[2]) begin
                    if (!div_trial[XLEN]) begin
                        rem_q <= div_trial;
                        acc_q <= {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= div_shift;
                        acc_q <= {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                end
            end else if (state_q == StFin) begin
                result_q <= final_val;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected results with due cycle,
// a negedge monitor checks every done/illegal pulse against them.
module tb_muldiv_unit;
    logic        clk, reset, start;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, result;
    logic        busy, done, illegal;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .func3(func3),
        .func7(func7), .rs1(rs1), .rs2(rs2), .busy(busy), .done(done),
        .result(result), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          zero_cyc = -1;
    int          ill_cyc = -1;
    int          hold_cyc = -1;
    logic [31:0] hold_val = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (sb.size() == 0 || sb[0].due != cyc) begin
                errors++;
                $display("FAIL unexpected_done cycle=%0d result=%h required no done", cyc, result);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL %s result=%h required=%h", e.name, result, e.res);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_missing_done cycle=%0d required done at %0d", e.name, cyc, e.due);
        end
        if (illegal || cyc == ill_cyc) begin
            checks++;
            if (illegal !== (cyc == ill_cyc)) begin
                errors++;
                $display("FAIL illegal_pulse cycle=%0d illegal=%b required=%b",
                         cyc, illegal, (cyc == ill_cyc));
            end
        end
        if (cyc == ill_cyc) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_busy busy=%b required=0", busy);
            end
        end
        if (cyc == zero_cyc) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_state busy=%b done=%b illegal=%b result=%h required 0/0/0/0",
                         busy, done, illegal, result);
            end
        end
        if (cyc == hold_cyc) begin
            checks++;
            if (result !== hold_val) begin
                errors++;
                $display("FAIL result_hold result=%h required=%h", result, hold_val);
            end
        end
    end

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] exp_res,
                         input int lat, input string name);
        exp_t e;
        @(posedge clk); #1;
        opcode = 7'b0110011; func7 = f7; func3 = f3; rs1 = a; rs2 = b; start = 1'b1;
        if (push) begin
            e.res = exp_res; e.due = cyc + lat; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; func3 = 3'($urandom);
    endtask

    task automatic wait_done();
        repeat (60) begin
            @(negedge clk);
            if (done) return;
        end
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input string name);
        issue(7'h01, f3, a, b, 1'b1, exp_res, lat, name);
        wait_done();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; func3 = '0; func7 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        zero_cyc = cyc;

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_neg");
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulhsu");
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg");
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_neg");
        run(3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, "divu");
        run(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");
        run(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, "divu_by_zero");
        run(3'd7, 32'h1234, 32'd0, 32'h1234, 2, "remu_by_zero");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_overflow");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, "rem_overflow");

        // start while busy is dropped
        issue(7'h01, 3'd5, 32'd100, 32'd7, 1'b1, 32'd14, 34, "divu_busy");
        repeat (4) @(posedge clk);
        issue(7'h01, 3'd0, 32'd3, 32'd3, 1'b0, 32'd0, 0, "");
        wait_done();
        repeat (40) @(posedge clk);

        // back-to-back, second start the cycle after done
        run(3'd0, 32'd3, 32'd5, 32'd15, 34, "mul_first");
        run(3'd0, 32'h1234, 32'h10, 32'h1_2340, 34, "mul_b2b");
        hold_val = 32'h1_2340;
        #1 hold_cyc = cyc + 5;
        repeat (8) @(posedge clk);

        // non-M encoding: one illegal pulse, result untouched
        issue(7'h00, 3'd0, 32'd9, 32'd9, 1'b0, 32'd0, 0, "");
        ill_cyc = cyc;
        hold_cyc = cyc;
        repeat (40) @(posedge clk);

        // reset in cycle 10 of a DIV aborts it
        issue(7'h01, 3'd4, 32'd100, 32'hFFFF_FFFD, 1'b0, 32'd0, 0, "");
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        zero_cyc = cyc;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (45) @(posedge clk);
        run(3'd4, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFDF, 34, "div_after_reset");

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
